// File: rtl/aes_arbiter.sv
// Round-robin arbiter sequencing NREQ requesters through one shared aes_control core.
// Registered outputs; one job in flight; results held until rsp_accept; watchdog aborts silent jobs.
module aes_arbiter #(
  parameter int NREQ    = 2,
  parameter int DW      = 128,
  parameter int TIMEOUT = 1023,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    grant,
  output logic               aes_ready,
  output logic [DW-1:0]      aes_data_in,
  input  logic               aes_complete,
  input  logic [DW-1:0]      aes_data_out,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW-1:0]      rsp_data,
  input  logic               rsp_accept,
  output logic               timeout_err,
  output logic               busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state, state_nxt;
  logic [TW-1:0]  timer;
  logic [IDW-1:0] last_id;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] cand;
  logic           found;

  // Scan starts one past the last winner so every active requester is served within NREQ jobs.
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = IDW'((int'(last_id) + off) % NREQ);
      if (!found && req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (found) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (aes_complete)                state_nxt = RESP;
        else if (timer == TW'(TIMEOUT))  state_nxt = IDLE;
      end
      RESP:  if (rsp_accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      grant       <= '0;
      aes_ready   <= 1'b0;
      aes_data_in <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_data    <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      timer       <= '0;
      last_id     <= IDW'(NREQ - 1);
    end else begin
      grant       <= '0;
      aes_ready   <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (found) begin
            aes_data_in <= req_data[int'(sel)*DW +: DW];
            last_id     <= sel;
            rsp_id      <= sel;
            grant       <= NREQ'(1) << sel;
            aes_ready   <= 1'b1;
          end
        end
        ISSUE: timer <= '0;
        WAIT: begin
          timer <= timer + TW'(1);
          if (aes_complete) begin
            rsp_data  <= aes_data_out;
            rsp_valid <= 1'b1;
          end else if (timer == TW'(TIMEOUT)) begin
            timeout_err <= 1'b1;
          end
        end
        RESP: if (rsp_accept) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/aes_arbiter.md
Name: aes_arbiter

Overview:
Shares the single aes_control core between NREQ block requesters, for example the extract_fifo packer and a second extract channel. It arbitrates 128-bit plaintext requests round-robin and sequences each job through the core: issue pulse, wait for complete, return the result. Results go back tagged with the requester id, and a watchdog aborts a job when the core does not answer.

Parameters:
NREQ, 2, number of requesters (>=2)
DW, 128, block width in bits
TIMEOUT, 1023, max cycles to wait for aes_complete after issue
IDW, $clog2(NREQ), requester id width

Ports:
clk  in  1  system clock
n_rst  in  1  async active-low reset
req  in  NREQ  per-requester level request; data valid while high
req_data  in  NREQ*DW  requester i block at [i*DW +: DW]
grant  out  NREQ  one-hot, one-cycle pulse: requester's block captured
aes_ready  out  1  one-cycle start pulse to aes_control.ready
aes_data_in  out  DW  block to aes_control.data_in
aes_complete  in  1  aes_control.complete
aes_data_out  in  DW  aes_control.data_out
rsp_valid  out  1  result available
rsp_id  out  IDW  requester owning the result
rsp_data  out  DW  encrypted block
rsp_accept  in  1  consumer takes the result
timeout_err  out  1  one-cycle pulse when a job is aborted
busy  out  1  high in any state other than IDLE

Behaviour:
Clocking and reset:
- Clock is clk; reset is n_rst, asynchronous, active-low.
- All outputs are registered.
- Reset values: grant=0, aes_ready=0, aes_data_in=0, rsp_valid=0, rsp_id=0, rsp_data=0, timeout_err=0, busy=0, state=IDLE, timer=0, last_id=NREQ-1.
- Reset mid-job drops the job; no response and no error are produced, and any late aes_complete is ignored.

FSM (states IDLE, ISSUE, WAIT, RESP):
- IDLE: on an edge with req!=0, select the first set bit scanning from (last_id+1) mod NREQ upward with wrap.
  - Latch req_data slice into aes_data_in; set last_id=sel and rsp_id=sel; go to ISSUE.
  - With req=0, stay in IDLE.
- ISSUE: lasts exactly one cycle.
  - grant[sel]=1 and aes_ready=1 during this cycle; timer cleared; go to WAIT.
- WAIT: timer increments each cycle.
  - If aes_complete=1: rsp_data<=aes_data_out, rsp_valid<=1, go to RESP.
  - Else if timer==TIMEOUT: timeout_err pulse next cycle, go to IDLE, no response.
  - aes_complete beats timeout in the same cycle.
- RESP: rsp_valid, rsp_id and rsp_data are held stable until rsp_accept=1.
  - On that edge rsp_valid<=0 and go to IDLE.
  - Next arbitration earliest on the following edge.

Latency and handshake:
- Latency: req sampled at edge k, grant/aes_ready high in cycle k+1. With aes_complete in cycle k+1+L, rsp_valid is high from cycle k+2+L.
- Requester must hold req and req_data stable until it sees grant, then drop req.
- A req still high on the next IDLE arbitration is treated as a new request.

Boundary conditions:
- aes_complete outside WAIT is ignored.
- Simultaneous requests: exactly one grant per job; round-robin guarantees each active requester is served within NREQ jobs.
- aes_data_in is held until the next capture.
- rsp_accept outside RESP is ignored.

Test Plan:
- Reset then req=2'b01 with data 0x00112233_44556677_8899AABB_CCDDEEFF → grant=01 and aes_ready=1 both one cycle after the sample edge; aes_data_in equals that data.
- Model core answers 12 cycles after aes_ready with 0x69C4E0D8_6A7B0430_D8CDB780_70B4C55A → rsp_valid=1, rsp_id=0, data exact; held for 5 cycles with rsp_accept=0, dropped one cycle after accept.
- req=2'b11 held for 4 jobs → grants in order 01, 10, 01, 10; no overlap; busy high in every non-IDLE cycle.
- Core never completes → timeout_err pulses after TIMEOUT+1 WAIT cycles, no rsp_valid, FSM back in IDLE and accepts the next req.
- n_rst asserted during WAIT, then aes_complete pulse after release → all outputs at reset values, no rsp_valid; first grant after reset goes to requester 0.
- aes_complete pulses while IDLE and during RESP → ignored; rsp_data unchanged.
